// File: rtl/ins_prefetch.sv
// Instruction prefetch: sequential byte reads from program memory into a small
// FIFO, presented to the decoder with valid/ready; flush redirects fetching.
module ins_prefetch #(
    parameter int DEPTH       = 4,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    output logic [7:0]  ins_byte,
    output logic [15:0] ins_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    input  logic        flush,
    input  logic [15:0] flush_pc
);

    localparam int            AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0]    W_LAST = 3'(WAIT_CYCLES);
    localparam logic [AW:0]   FULL   = (AW+1)'(DEPTH);

    typedef enum logic {S_IDLE, S_READ} state_t;

    state_t        r_state;
    logic [15:0]   r_fetch_addr;
    logic [15:0]   r_mem_addr;
    logic          r_mem_rd;
    logic [2:0]    r_wcnt;
    logic [AW:0]   r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [7:0]    r_data [DEPTH];
    logic [15:0]   r_pc   [DEPTH];

    logic          w_push;
    logic          w_pop;
    logic [AW:0]   w_count_nxt;
    logic [15:0]   w_fetch_inc;

    assign ins_valid   = (r_count != '0);
    assign ins_byte    = r_data[r_rd_ptr];
    assign ins_pc      = r_pc[r_rd_ptr];
    assign mem_addr    = r_mem_addr;
    assign mem_rd      = r_mem_rd;

    assign w_push      = (r_state == S_READ) && (r_wcnt == W_LAST);
    assign w_pop       = ins_valid && ins_ready;
    assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign w_fetch_inc = r_fetch_addr + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_fetch_addr <= 16'h0000;
            r_mem_addr   <= 16'h0000;
            r_mem_rd     <= 1'b0;
            r_wcnt       <= 3'd0;
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= 8'h00;
                r_pc[i]   <= 16'h0000;
            end
        end else if (flush) begin
            // In-flight read is dropped; a handshake this cycle is simply consumed.
            r_state      <= S_IDLE;
            r_fetch_addr <= flush_pc;
            r_mem_rd     <= 1'b0;
            r_wcnt       <= 3'd0;
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
        end else begin
            if (w_push) begin
                r_data[r_wr_ptr] <= mem_data;
                r_pc[r_wr_ptr]   <= r_fetch_addr;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;

            case (r_state)
                S_IDLE: begin
                    // Space is judged on the registered count, so a pop lands one cycle later.
                    if (r_count < FULL) begin
                        r_state    <= S_READ;
                        r_wcnt     <= 3'd0;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= r_fetch_addr;
                    end
                end
                S_READ: begin
                    if (w_push) begin
                        r_fetch_addr <= w_fetch_inc;
                        r_wcnt       <= 3'd0;
                        if (w_count_nxt < FULL) begin
                            r_mem_addr <= w_fetch_inc;
                        end else begin
                            r_state  <= S_IDLE;
                            r_mem_rd <= 1'b0;
                        end
                    end else begin
                        r_wcnt <= r_wcnt + 3'd1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_mem_rd <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ins_prefetch.sv
// Bench for ins_prefetch: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, plus a WAIT_CYCLES=0 instance.
module tb_ins_prefetch;

    localparam int DEPTH = 4;
    localparam int W     = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_addr, ins_pc, flush_pc;
    logic        mem_rd, ins_valid, ins_ready, flush;
    logic [7:0]  mem_data, ins_byte;

    logic [15:0] f_mem_addr, f_ins_pc;
    logic        f_mem_rd, f_ins_valid;
    logic [7:0]  f_mem_data, f_ins_byte;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit fast_en = 1'b0;

    always #5 clk = ~clk;

    assign mem_data   = mem_addr[7:0] ^ 8'hA5;
    assign f_mem_data = f_mem_addr[7:0] ^ 8'hA5;

    ins_prefetch #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_data(mem_data), .ins_byte(ins_byte), .ins_pc(ins_pc),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .flush(flush),
        .flush_pc(flush_pc));

    ins_prefetch #(.DEPTH(4), .WAIT_CYCLES(0)) u_fast (
        .clk(clk), .reset(reset), .mem_addr(f_mem_addr), .mem_rd(f_mem_rd),
        .mem_data(f_mem_data), .ins_byte(f_ins_byte), .ins_pc(f_ins_pc),
        .ins_valid(f_ins_valid), .ins_ready(1'b1), .flush(1'b0),
        .flush_pc(16'h0000));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Cycle 1 is the first cycle with reset low.
    always @(posedge clk) cyc <= reset ? 1 : cyc + 1;

    // Reference model: byte queue, fetch pointer, and one outstanding read.
    logic [23:0] q[$];
    logic [15:0] m_fetch, m_addr;
    bit          m_busy;
    int          m_left;

    always @(posedge clk) begin
        int sz0;
        if (reset) begin
            q.delete(); m_fetch = 16'h0; m_addr = 16'h0; m_busy = 0; m_left = 0;
        end else if (flush) begin
            q.delete(); m_busy = 0; m_fetch = flush_pc;
        end else begin
            sz0 = q.size();
            if (sz0 > 0 && ins_ready) void'(q.pop_front());
            if (m_busy) begin
                if (m_left == 0) begin
                    q.push_back({m_fetch, m_fetch[7:0] ^ 8'hA5});
                    m_fetch = m_fetch + 16'd1;
                    if (q.size() < DEPTH) begin m_left = W; m_addr = m_fetch; end
                    else m_busy = 0;
                end else begin
                    m_left--;
                end
            end else if (sz0 < DEPTH) begin
                m_busy = 1; m_left = W; m_addr = m_fetch;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("valid", 32'(ins_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                check("ins_pc", 32'(ins_pc), 32'(q[0][23:8]));
                check("ins_byte", 32'(ins_byte), 32'(q[0][7:0]));
            end
            check("mem_rd", 32'(mem_rd), 32'(m_busy));
            if (m_busy) check("mem_addr", 32'(mem_addr), 32'(m_addr));
            if (fast_en && cyc >= 3 && cyc <= 20) begin
                check("w0_valid", 32'(f_ins_valid), 32'd1);
                check("w0_pc", 32'(f_ins_pc), 32'(cyc - 3));
                check("w0_byte", 32'(f_ins_byte), 32'(8'(cyc - 3) ^ 8'hA5));
                check("w0_rd", 32'(f_mem_rd), 32'd1);
                check("w0_addr", 32'(f_mem_addr), 32'(cyc - 2));
            end
        end
    end

    task automatic go(input int n);
        int k = 0;
        while (cyc != n && k < 1000) begin @(posedge clk); #2; k++; end
        check("reach_cycle", 32'(cyc), 32'(n));
    endtask

    task automatic chk_at(input int n);
        go(n);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_valid", 32'(ins_valid), 32'd0);
        check("rst_byte", 32'(ins_byte), 32'd0);
        check("rst_pc", 32'(ins_pc), 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;
    endtask

    initial begin
        int rdc;
        reset = 1'b1; ins_ready = 1'b0; flush = 1'b0; flush_pc = 16'h0;

        // Startup timing, ready high; WAIT_CYCLES=0 instance streams alongside.
        ins_ready = 1'b1;
        do_reset();
        fast_en = 1'b1;
        chk_at(1);  check("t1_rd_c1", 32'(mem_rd), 32'd0);
        chk_at(2);  check("t1_rd_c2", 32'(mem_rd), 32'd1);
                    check("t1_addr_c2", 32'(mem_addr), 32'h0000);
                    check("w0_rd_c2", 32'(f_mem_rd), 32'd1);
        chk_at(4);  check("t1_valid_c4", 32'(ins_valid), 32'd0);
        chk_at(5);  check("t1_valid_c5", 32'(ins_valid), 32'd1);
                    check("t1_byte_c5", 32'(ins_byte), 32'hA5);
                    check("t1_pc_c5", 32'(ins_pc), 32'h0000);
        chk_at(8);  check("t1_byte_c8", 32'(ins_byte), 32'hA4);
                    check("t1_pc_c8", 32'(ins_pc), 32'h0001);
        chk_at(22);
        fast_en = 1'b0;

        // Decoder stalled: exactly four reads, then fill and stop.
        ins_ready = 1'b0;
        do_reset();
        rdc = 0;
        for (int c = 1; c <= 39; c++) begin
            chk_at(c);
            if (mem_rd) rdc++;
        end
        check("t2_read_cycles", 32'(rdc), 32'd12);
        check("t2_rd_idle", 32'(mem_rd), 32'd0);
        check("t2_byte_held", 32'(ins_byte), 32'hA5);

        // Single pop from full: refill read of 0x0004 begins two cycles later.
        go(40); ins_ready = 1'b1;
        go(41); ins_ready = 1'b0;
        @(negedge clk);
        check("t3_pc_c41", 32'(ins_pc), 32'h0001);
        check("t3_byte_c41", 32'(ins_byte), 32'hA4);
        check("t3_rd_c41", 32'(mem_rd), 32'd0);
        chk_at(42); check("t3_rd_c42", 32'(mem_rd), 32'd1);
                    check("t3_addr_c42", 32'(mem_addr), 32'h0004);
        for (int c = 45; c <= 80; c++) begin
            go(c);
            ins_ready = (c % 3 != 0);
        end
        ins_ready = 1'b0;
        chk_at(85);

        // Flush during second cycle of the 0x0002 read.
        do_reset();
        chk_at(9);  check("t4_addr_c9", 32'(mem_addr), 32'h0002);
        go(9);
        go(9);
        flush = 1'b1; flush_pc = 16'h0123;
        go(10); flush = 1'b0;
        @(negedge clk);
        check("t4_valid_c10", 32'(ins_valid), 32'd0);
        check("t4_rd_c10", 32'(mem_rd), 32'd0);
        chk_at(11); check("t4_addr_c11", 32'(mem_addr), 32'h0123);
        go(14); ins_ready = 1'b1;
        @(negedge clk);
        check("t4_pc_c14", 32'(ins_pc), 32'h0123);
        check("t4_byte_c14", 32'(ins_byte), 32'h86);
        chk_at(17); check("t4_pc_c17", 32'(ins_pc), 32'h0124);
                    check("t4_byte_c17", 32'(ins_byte), 32'h81);
        chk_at(25);

        // Held flush, then address wrap from 0xFFFE.
        do_reset();
        go(3); flush = 1'b1; flush_pc = 16'hFFF0;
        go(4); flush_pc = 16'hFFFE;
        @(negedge clk); check("t5_rd_c4", 32'(mem_rd), 32'd0);
        go(5); flush = 1'b0;
        @(negedge clk); check("t5_rd_c5", 32'(mem_rd), 32'd0);
        chk_at(6);  check("t5_addr_c6", 32'(mem_addr), 32'hFFFE);
        chk_at(9);  check("t5_pc_c9", 32'(ins_pc), 32'hFFFE);
                    check("t5_byte_c9", 32'(ins_byte), 32'h5B);
        chk_at(12); check("t5_pc_c12", 32'(ins_pc), 32'hFFFF);
                    check("t5_addr_c12", 32'(mem_addr), 32'h0000);
        chk_at(15); check("t5_pc_c15", 32'(ins_pc), 32'h0000);
                    check("t5_byte_c15", 32'(ins_byte), 32'hA5);
        chk_at(25);

        // Flush coinciding with a completed handshake.
        do_reset();
        go(11); flush = 1'b1; flush_pc = 16'h0040;
        @(negedge clk); check("t6_valid_c11", 32'(ins_valid), 32'd1);
                        check("t6_pc_c11", 32'(ins_pc), 32'h0002);
        go(12); flush = 1'b0;
        chk_at(16); check("t6_pc_c16", 32'(ins_pc), 32'h0040);
        chk_at(30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
